// File: rtl/perf_ctr_pkg.sv
// Shared constants and address helpers for the memory-mapped performance counter bank.
// Word addresses, CTRL field positions and per-channel counter address helpers.
package perf_ctr_pkg;

   localparam int ADDR_CTRL       = 0;
   localparam int ADDR_OVF        = 1;
   localparam int ADDR_STALL_MASK = 2;
   localparam int ADDR_CNT_BASE   = 4;

   localparam int CTRL_EN         = 0;
   localparam int CTRL_CLR        = 1;
   localparam int CTRL_IRQ_EN_LSB = 8;

   localparam int MAX_CNT         = 8;

   function automatic logic [31:0] cnt_lo_addr(input int ch);
      return 32'(ADDR_CNT_BASE + 2 * ch);
   endfunction

   function automatic logic [31:0] cnt_hi_addr(input int ch);
      return 32'(ADDR_CNT_BASE + 2 * ch + 1);
   endfunction

endpackage

// File: rtl/perf_ctr_channel.sv
// One performance counter channel: clear, partial lo/hi word writes and gated increment.
// wrap pulses in the cycle an increment rolls the counter from all-ones to zero.
module perf_ctr_channel
   import perf_ctr_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   input  logic             wr_lo,
   input  logic             wr_hi,
   input  logic [31:0]      wr_data,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   logic [63:0] cur64;
   logic [63:0] nxt64;
   logic        unused_nxt;

   // Work on a 64-bit view so a write replaces only the addressed word.
   assign cur64      = 64'(cnt);
   assign nxt64      = {(wr_hi ? wr_data : cur64[63:32]), (wr_lo ? wr_data : cur64[31:0])};
   assign unused_nxt = ^nxt64;

   // A clear or a write swallows the increment, so no wrap can happen alongside them.
   assign wrap = inc && !clr && !wr_lo && !wr_hi && (&cnt);

   always_ff @(posedge CLK) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (wr_lo || wr_hi) begin
         cnt <= nxt64[CNT_W-1:0];
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of NUM_CNT event counters with stall gating, sticky overflow and an IRQ.
// Holds the address decode, CTRL/OVF/STALL_MASK registers, hi shadow, read mux and IRQ register.
module perf_counter_bank
   import perf_ctr_pkg::*;
#(
   parameter int NUM_CNT = 4,
   parameter int CNT_W   = 32,
   parameter int ADDR_W  = 4
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic [NUM_CNT-1:0] evt,       // per-channel event pulse ("event" is a reserved word)
   input  logic               stall,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [31:0]        rd_data,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [31:0]        wr_data,
   output logic               ovf_irq
);

   // Handshake: rd_en/wr_en are single-cycle strobes with no backpressure; a read
   // issued in cycle N has rd_data valid in N+1, and rd_data holds until the next read.

   logic [31:0]        wa;
   logic [31:0]        ra;
   logic               ctrl_en;
   logic [NUM_CNT-1:0] irq_en;
   logic [NUM_CNT-1:0] ovf;
   logic [NUM_CNT-1:0] ovf_n;
   logic [NUM_CNT-1:0] stall_mask;
   logic [NUM_CNT-1:0] inc;
   logic [NUM_CNT-1:0] wrap;
   logic [NUM_CNT-1:0] wr_lo;
   logic [NUM_CNT-1:0] wr_hi;
   logic               wr_ctrl;
   logic               wr_ovf;
   logic               wr_mask;
   logic               clr;
   logic [31:0]        hi_shadow;
   logic [31:0]        shadow_n;
   logic [31:0]        rd_mux;
   logic [CNT_W-1:0]   cnt   [NUM_CNT];
   logic [63:0]        cnt64 [NUM_CNT];

   assign wa = 32'(wr_addr);
   assign ra = 32'(rd_addr);

   assign wr_ctrl = wr_en && (wa == 32'(ADDR_CTRL));
   assign wr_ovf  = wr_en && (wa == 32'(ADDR_OVF));
   assign wr_mask = wr_en && (wa == 32'(ADDR_STALL_MASK));
   assign clr     = wr_ctrl && wr_data[CTRL_CLR];

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
      assign inc[i]   = ctrl_en & evt[i] & ~(stall_mask[i] & stall);
      assign wr_lo[i] = wr_en && (wa == cnt_lo_addr(i));
      // Narrow counters have no hi bits, so a hi-word write is not a write at all.
      assign wr_hi[i] = (CNT_W > 32) && wr_en && (wa == cnt_hi_addr(i));
      assign cnt64[i] = 64'(cnt[i]);

      perf_ctr_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .CLK     (CLK),
         .reset   (reset),
         .inc     (inc[i]),
         .clr     (clr),
         .wr_lo   (wr_lo[i]),
         .wr_hi   (wr_hi[i]),
         .wr_data (wr_data),
         .cnt     (cnt[i]),
         .wrap    (wrap[i])
      );
   end

   // Wrap is OR-ed in last so it beats a same-cycle write-1-to-clear.
   always_comb begin
      ovf_n = ovf;
      if (clr) begin
         ovf_n = '0;
      end else if (wr_ovf) begin
         ovf_n = ovf & ~wr_data[NUM_CNT-1:0];
      end
      ovf_n = ovf_n | wrap;
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         ctrl_en    <= 1'b0;
         irq_en     <= '0;
         stall_mask <= '0;
         ovf        <= '0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en <= wr_data[CTRL_EN];
            irq_en  <= wr_data[CTRL_IRQ_EN_LSB +: NUM_CNT];
         end
         if (wr_mask) begin
            stall_mask <= wr_data[NUM_CNT-1:0];
         end
         ovf <= ovf_n;
      end
   end

   // Read mux sees pre-write register values; a lo read also captures the hi bits.
   always_comb begin
      rd_mux   = '0;
      shadow_n = hi_shadow;
      if (ra == 32'(ADDR_CTRL)) begin
         rd_mux[CTRL_EN]                     = ctrl_en;
         rd_mux[CTRL_IRQ_EN_LSB +: NUM_CNT]  = irq_en;
      end else if (ra == 32'(ADDR_OVF)) begin
         rd_mux[NUM_CNT-1:0] = ovf;
      end else if (ra == 32'(ADDR_STALL_MASK)) begin
         rd_mux[NUM_CNT-1:0] = stall_mask;
      end
      for (int i = 0; i < NUM_CNT; i++) begin
         if (ra == cnt_lo_addr(i)) begin
            rd_mux   = cnt64[i][31:0];
            shadow_n = cnt64[i][63:32];
         end
         if (ra == cnt_hi_addr(i)) begin
            rd_mux = hi_shadow;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         rd_data   <= '0;
         hi_shadow <= '0;
         ovf_irq   <= 1'b0;
      end else begin
         if (rd_en) begin
            rd_data   <= rd_mux;
            hi_shadow <= shadow_n;
         end
         ovf_irq <= |(ovf & irq_en);
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a 32-bit and a 64-bit instance share stimulus and are
// checked every cycle against an arithmetic reference model, plus directed constant checks.
module tb_perf_counter_bank;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  evt = '0;
   logic        stall = 1'b0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd32, rd64;
   logic        irq32, irq64;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   perf_counter_bank #(.NUM_CNT(4), .CNT_W(32), .ADDR_W(4)) u_dut32 (
      .CLK(CLK), .reset(reset), .evt(evt), .stall(stall),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd32),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ovf_irq(irq32)
   );

   perf_counter_bank #(.NUM_CNT(4), .CNT_W(64), .ADDR_W(4)) u_dut64 (
      .CLK(CLK), .reset(reset), .evt(evt), .stall(stall),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd64),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ovf_irq(irq64)
   );

   // Reference model: index 0 models the 32-bit instance, index 1 the 64-bit one.
   logic [63:0] m_cnt    [2][4];
   logic [3:0]  m_ovf    [2];
   logic [31:0] m_shadow [2];
   logic [31:0] m_rd     [2];
   logic        m_iq     [2];
   logic        m_en;
   logic [3:0]  m_irq_en;
   logic [3:0]  m_mask;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int          wa, ra, w, c;
      logic        clr;
      logic [63:0] msk, v;
      logic [3:0]  wraps;
      logic [31:0] rv, sh;
      wa  = int'(wr_addr);
      ra  = int'(rd_addr);
      clr = wr_en && (wa == 0) && wr_data[1];
      for (int d = 0; d < 2; d++) begin
         w   = (d == 0) ? 32 : 64;
         msk = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
         rv  = m_rd[d];
         sh  = m_shadow[d];
         if (rd_en) begin
            rv = 32'd0;
            if (ra == 0) rv = 32'(m_en) | (32'(m_irq_en) << 8);
            else if (ra == 1) rv = 32'(m_ovf[d]);
            else if (ra == 2) rv = 32'(m_mask);
            else if (ra >= 4 && ra < 12) begin
               c = (ra - 4) / 2;
               if (ra % 2 == 0) begin
                  rv = m_cnt[d][c][31:0];
                  sh = m_cnt[d][c][63:32];
               end else begin
                  rv = m_shadow[d];
               end
            end
         end
         m_iq[d] = |(m_ovf[d] & m_irq_en);
         wraps = 4'd0;
         for (int k = 0; k < 4; k++) begin
            v = m_cnt[d][k];
            if (clr) v = 64'd0;
            else if (wr_en && wa == 4 + 2 * k) v = {v[63:32], wr_data} & msk;
            else if (wr_en && wa == 5 + 2 * k && w > 32) v = {wr_data, v[31:0]} & msk;
            else if (m_en && evt[k] && !(m_mask[k] && stall)) begin
               if (v == msk) begin
                  v = 64'd0;
                  wraps[k] = 1'b1;
               end else begin
                  v = v + 64'd1;
               end
            end
            m_cnt[d][k] = v;
         end
         if (clr) m_ovf[d] = 4'd0;
         else begin
            if (wr_en && wa == 1) m_ovf[d] = m_ovf[d] & ~wr_data[3:0];
            m_ovf[d] = m_ovf[d] | wraps;
         end
         m_rd[d]     = rv;
         m_shadow[d] = sh;
         if (reset) begin
            for (int k = 0; k < 4; k++) m_cnt[d][k] = 64'd0;
            m_ovf[d]    = 4'd0;
            m_shadow[d] = 32'd0;
            m_rd[d]     = 32'd0;
            m_iq[d]     = 1'b0;
         end
      end
      if (reset) begin
         m_en     = 1'b0;
         m_irq_en = 4'd0;
         m_mask   = 4'd0;
      end else if (wr_en) begin
         if (wa == 0) begin
            m_en     = wr_data[0];
            m_irq_en = wr_data[11:8];
         end
         if (wa == 2) m_mask = wr_data[3:0];
      end
   endtask

   // One clock: advance the model with the current inputs, then compare all outputs.
   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
      check("rd32", rd32, m_rd[0]);
      check("rd64", rd64, m_rd[1]);
      check("irq32", 32'(irq32), 32'(m_iq[0]));
      check("irq64", 32'(irq64), 32'(m_iq[1]));
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      // Reset and idle read-back of every address.
      reset = 1'b1;
      repeat (3) tick();
      check("rst_rd32", rd32, 32'd0);
      check("rst_irq32", 32'(irq32), 32'd0);
      reset = 1'b0;
      for (int a = 0; a < 16; a++) begin
         rd(4'(a));
         check("t1_rd32", rd32, 32'd0);
         check("t1_rd64", rd64, 32'd0);
      end
      check("t1_irq64", 32'(irq64), 32'd0);

      // Ten events on channel 0.
      wr(4'd0, 32'h1);
      evt = 4'b0001;
      repeat (10) tick();
      evt = 4'b0000;
      rd(4'd4);  check("t2_ch0", rd32, 32'd10); check("t2_ch0_64", rd64, 32'd10);
      rd(4'd6);  check("t2_ch1", rd32, 32'd0);
      rd(4'd8);  check("t2_ch2", rd32, 32'd0);
      rd(4'd10); check("t2_ch3", rd32, 32'd0);

      // Stall masking on channel 1 only.
      wr(4'd0, 32'h3);
      wr(4'd2, 32'h2);
      evt = 4'b0011;
      for (int k = 0; k < 8; k++) begin
         stall = (k >= 2 && k <= 4);
         tick();
      end
      evt = 4'b0000; stall = 1'b0;
      rd(4'd6); check("t3_ch1", rd32, 32'd5);
      rd(4'd4); check("t3_ch0", rd32, 32'd8);
      rd(4'd2); check("t3_mask", rd32, 32'd2);

      // Wrap of a 32-bit counter, overflow IRQ and write-1-to-clear.
      wr(4'd0, 32'h401);
      wr(4'd8, 32'hFFFF_FFFF);
      evt = 4'b0100;
      tick();
      evt = 4'b0000;
      check("t4_irq_early", 32'(irq32), 32'd0);
      tick();
      check("t4_irq_set", 32'(irq32), 32'd1);
      check("t4_irq64", 32'(irq64), 32'd0);
      rd(4'd8); check("t4_ch2", rd32, 32'd0); check("t4_ch2_lo64", rd64, 32'd0);
      rd(4'd9); check("t4_ch2_hi64", rd64, 32'd1);
      rd(4'd1); check("t4_ovf", rd32, 32'h4);
      wr(4'd1, 32'h4);
      tick();
      check("t4_irq_clr", 32'(irq32), 32'd0);
      // Wrap and W1C in the same cycle: the bit stays set.
      wr(4'd8, 32'hFFFF_FFFF);
      evt = 4'b0100;
      wr(4'd1, 32'h4);
      evt = 4'b0000;
      rd(4'd1); check("t4_ovf_setwins", rd32, 32'h4);

      // Atomic 64-bit read through the hi shadow.
      wr(4'd0, 32'h3);
      wr(4'd5, 32'h1);
      wr(4'd4, 32'hFFFF_FFFF);
      rd(4'd4); check("t5_lo", rd64, 32'hFFFF_FFFF);
      evt = 4'b0001;
      tick();
      evt = 4'b0000;
      rd(4'd5); check("t5_hi_shadow", rd64, 32'd1); check("t5_hi32", rd32, 32'd0);
      rd(4'd4); check("t5_lo_new", rd64, 32'd0);
      rd(4'd5); check("t5_hi_new", rd64, 32'd2);

      // CLR and counter write racing events.
      evt = 4'b1111;
      wr(4'd0, 32'h3);
      evt = 4'b0000;
      rd(4'd4); check("t6_clr_ch0", rd32, 32'd0);
      rd(4'd6); check("t6_clr_ch1", rd64, 32'd0);
      rd(4'd0); check("t6_ctrl", rd32, 32'h1);
      evt = 4'b1111;
      wr(4'd6, 32'h1234);
      evt = 4'b0000;
      rd(4'd6); check("t6_wr32", rd32, 32'h1234); check("t6_wr64", rd64, 32'h1234);

      // Randomised traffic against the model.
      wr(4'd0, 32'h0F01);
      for (int n = 0; n < 600; n++) begin
         evt     = 4'($urandom_range(0, 15));
         stall   = ($urandom_range(0, 3) == 0);
         rd_en   = ($urandom_range(0, 1) == 1);
         rd_addr = 4'($urandom_range(0, 15));
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = 4'($urandom_range(0, 15));
         if (wr_addr == 4'd0)
            wr_data = (32'($urandom_range(0, 15)) << 8) | (32'($urandom_range(0, 9) == 0) << 1)
                      | 32'($urandom_range(0, 4) != 0);
         else if (wr_addr >= 4'd4 && $urandom_range(0, 1) == 1)
            wr_data = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         else
            wr_data = $urandom;
         reset = ($urandom_range(0, 249) == 0);
         tick();
      end
      reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; evt = 4'b0000; stall = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
